// File: rtl/synth_pkg.sv
// Shared types and constants for the voice allocator and its channel slots.
package synth_pkg;

  localparam int unsigned MAX_FREQ = 20000;
  localparam int unsigned PITCH_W  = $clog2(MAX_FREQ);

  typedef enum logic [1:0] {WF_SQUARE, WF_TRIANGLE, WF_SINE, WF_SAWTOOTH} waveform_t;

  typedef enum logic [1:0] {IDLE, SCAN, APPLY} alloc_state_t;

endpackage

// File: rtl/voice_slot.sv
// One tone-channel slot: pitch, waveform, enable and (with VOICE_STEAL_EN) a saturating age.
module voice_slot #(
  parameter int unsigned PITCH_W = 15
`ifdef VOICE_STEAL_EN
  , parameter int unsigned AGE_W = 4
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               release_i,
  input  logic [PITCH_W-1:0] pitch_i,
  input  logic [1:0]         wf_i,
  output logic [PITCH_W-1:0] pitch_o,
  output logic [1:0]         wf_o,
  output logic               ena_o
`ifdef VOICE_STEAL_EN
  , input  logic             age_inc_i
  , output logic [AGE_W-1:0] age_o
`endif
);
  import synth_pkg::*;

  logic [PITCH_W-1:0] pitch_q, pitch_d;
  waveform_t          wf_q, wf_d;
  logic               ena_q, ena_d;

  always_comb begin
    pitch_d = pitch_q;
    wf_d    = wf_q;
    ena_d   = ena_q;
    if (load_i) begin
      pitch_d = pitch_i;
      wf_d    = waveform_t'(wf_i);
      ena_d   = 1'b1;
    end else if (release_i) begin
      ena_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pitch_q <= '0;
      wf_q    <= WF_SQUARE;
      ena_q   <= 1'b0;
    end else begin
      pitch_q <= pitch_d;
      wf_q    <= wf_d;
      ena_q   <= ena_d;
    end
  end

  assign pitch_o = pitch_q;
  assign wf_o    = wf_q;
  assign ena_o   = ena_q;

`ifdef VOICE_STEAL_EN
  logic [AGE_W-1:0] age_q, age_d;

  always_comb begin
    age_d = age_q;
    if (load_i)                       age_d = '0;
    else if (age_inc_i && age_q != '1) age_d = age_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) age_q <= '0;
    else        age_q <= age_d;
  end

  assign age_o = age_q;
`endif

endmodule

// File: rtl/voice_allocator.sv
// Polyphony controller: assigns note events to NUM_CH channel slots (retrigger/free/steal).
// Optional feature: define VOICE_STEAL_EN to steal the oldest channel when none are free.
module voice_allocator #(
  parameter  int unsigned NUM_CH   = 4,
  parameter  int unsigned MAX_FREQ = synth_pkg::MAX_FREQ,
  parameter  int unsigned AGE_W    = 4,
  localparam int unsigned PITCH_W  = $clog2(MAX_FREQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ev_valid,
  output logic                      ev_ready,
  input  logic                      ev_on,
  input  logic [PITCH_W-1:0]        ev_pitch,
  input  logic [1:0]                ev_waveform,
  output logic [NUM_CH*PITCH_W-1:0] ch_pitch,
  output logic [NUM_CH*2-1:0]       ch_waveform,
  output logic [NUM_CH-1:0]         ch_ena,
  output logic                      busy,
  output logic                      ev_dropped
);
  import synth_pkg::*;

  localparam int unsigned IDX_W = $clog2(NUM_CH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

  if (NUM_CH < 2 || NUM_CH > 16 || AGE_W < 1 || MAX_FREQ < 2) begin : g_param_check
    $error("voice_allocator: parameter out of range");
  end

  alloc_state_t       state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               on_q, on_d;
  logic [PITCH_W-1:0] lpitch_q, lpitch_d;
  logic [1:0]         lwf_q, lwf_d;
  logic               match_ok_q, match_ok_d, free_ok_q, free_ok_d;
  logic [IDX_W-1:0]   match_q, match_d, free_q, free_d;
  logic               drop_q, drop_d;
  logic               tgt_ok;
  logic [IDX_W-1:0]   tgt;

  logic [PITCH_W-1:0] pitch_a [NUM_CH];
  logic [1:0]         wf_a    [NUM_CH];
  logic [NUM_CH-1:0]  ena_v, load_v, rel_v;

`ifdef VOICE_STEAL_EN
  logic               old_ok_q, old_ok_d;
  logic [IDX_W-1:0]   old_q, old_d;
  logic [AGE_W-1:0]   old_age_q, old_age_d;
  logic [AGE_W-1:0]   age_a [NUM_CH];
  logic [NUM_CH-1:0]  age_inc_v;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
    voice_slot #(
      .PITCH_W(PITCH_W)
`ifdef VOICE_STEAL_EN
      , .AGE_W(AGE_W)
`endif
    ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_i    (load_v[i]),
      .release_i (rel_v[i]),
      .pitch_i   (lpitch_q),
      .wf_i      (lwf_q),
      .pitch_o   (pitch_a[i]),
      .wf_o      (wf_a[i]),
      .ena_o     (ena_v[i])
`ifdef VOICE_STEAL_EN
      , .age_inc_i (age_inc_v[i])
      , .age_o     (age_a[i])
`endif
    );
    assign ch_pitch[i*PITCH_W +: PITCH_W] = pitch_a[i];
    assign ch_waveform[i*2 +: 2]          = wf_a[i];
  end

  assign ch_ena     = ena_v;
  assign ev_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign ev_dropped = drop_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      on_q       <= 1'b0;
      lpitch_q   <= '0;
      lwf_q      <= '0;
      match_ok_q <= 1'b0;
      match_q    <= '0;
      free_ok_q  <= 1'b0;
      free_q     <= '0;
      drop_q     <= 1'b0;
`ifdef VOICE_STEAL_EN
      old_ok_q   <= 1'b0;
      old_q      <= '0;
      old_age_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      on_q       <= on_d;
      lpitch_q   <= lpitch_d;
      lwf_q      <= lwf_d;
      match_ok_q <= match_ok_d;
      match_q    <= match_d;
      free_ok_q  <= free_ok_d;
      free_q     <= free_d;
      drop_q     <= drop_d;
`ifdef VOICE_STEAL_EN
      old_ok_q   <= old_ok_d;
      old_q      <= old_d;
      old_age_q  <= old_age_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    on_d       = on_q;
    lpitch_d   = lpitch_q;
    lwf_d      = lwf_q;
    match_ok_d = match_ok_q;
    match_d    = match_q;
    free_ok_d  = free_ok_q;
    free_d     = free_q;
    drop_d     = 1'b0;
    load_v     = '0;
    rel_v      = '0;
    tgt_ok     = 1'b0;
    tgt        = '0;
`ifdef VOICE_STEAL_EN
    old_ok_d   = old_ok_q;
    old_d      = old_q;
    old_age_d  = old_age_q;
    age_inc_v  = '0;
`endif
    unique case (state_q)
      IDLE: begin
        if (ev_valid) begin
          on_d       = ev_on;
          lpitch_d   = ev_pitch;
          lwf_d      = ev_waveform;
          idx_d      = '0;
          match_ok_d = 1'b0;
          free_ok_d  = 1'b0;
`ifdef VOICE_STEAL_EN
          old_ok_d   = 1'b0;
`endif
          state_d    = SCAN;
        end
      end
      SCAN: begin
        // First hit wins for match/free; strict '>' keeps the lowest index on age ties.
        if (!match_ok_q && ena_v[idx_q] && pitch_a[idx_q] == lpitch_q) begin
          match_ok_d = 1'b1;
          match_d    = idx_q;
        end
        if (!free_ok_q && !ena_v[idx_q]) begin
          free_ok_d = 1'b1;
          free_d    = idx_q;
        end
`ifdef VOICE_STEAL_EN
        if (ena_v[idx_q] && (!old_ok_q || age_a[idx_q] > old_age_q)) begin
          old_ok_d  = 1'b1;
          old_d     = idx_q;
          old_age_d = age_a[idx_q];
        end
`endif
        if (idx_q == LAST_IDX) state_d = APPLY;
        else                   idx_d   = idx_q + 1'b1;
      end
      APPLY: begin
        state_d = IDLE;
        if (on_q) begin
          if (lpitch_q != '0) begin
            if (match_ok_q)     begin tgt_ok = 1'b1; tgt = match_q; end
            else if (free_ok_q) begin tgt_ok = 1'b1; tgt = free_q;  end
`ifdef VOICE_STEAL_EN
            else if (old_ok_q)  begin tgt_ok = 1'b1; tgt = old_q;   end
`endif
          end
          if (tgt_ok) begin
            load_v[tgt] = 1'b1;
`ifdef VOICE_STEAL_EN
            age_inc_v = ena_v & ~load_v;
`endif
          end else begin
            drop_d = 1'b1;
          end
        end else if (match_ok_q) begin
          rel_v[match_q] = 1'b1;
        end else begin
          drop_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Scoreboard bench for voice_allocator (NUM_CH = 4); expectations adapt to VOICE_STEAL_EN.
module tb_voice_allocator;

`ifdef VOICE_STEAL_EN
  localparam bit STEAL = 1'b1;
`else
  localparam bit STEAL = 1'b0;
`endif
  localparam int P0 = STEAL ? 600 : 440;
  localparam int W0 = STEAL ? 2 : 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ev_valid = 1'b0;
  logic        ev_ready;
  logic        ev_on = 1'b0;
  logic [14:0] ev_pitch = '0;
  logic [1:0]  ev_waveform = '0;
  logic [59:0] ch_pitch;
  logic [7:0]  ch_waveform;
  logic [3:0]  ch_ena;
  logic        busy;
  logic        ev_dropped;

  voice_allocator #(.NUM_CH(4), .MAX_FREQ(20000), .AGE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_on(ev_on), .ev_pitch(ev_pitch), .ev_waveform(ev_waveform),
    .ch_pitch(ch_pitch), .ch_waveform(ch_waveform), .ch_ena(ch_ena),
    .busy(busy), .ev_dropped(ev_dropped)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  ena;
    logic [59:0] p;
    logic [7:0]  w;
    logic        drop;
    int          acc;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  function automatic exp_t mk(input string nm, input logic [3:0] ena,
                              input int p0, input int p1, input int p2, input int p3,
                              input int w0, input int w1, input int w2, input int w3,
                              input logic drop);
    exp_t e;
    e.name = nm;
    e.ena  = ena;
    e.p    = {15'(p3), 15'(p2), 15'(p1), 15'(p0)};
    e.w    = {2'(w3), 2'(w2), 2'(w1), 2'(w0)};
    e.drop = drop;
    e.acc  = 0;
    return e;
  endfunction

  // Drive one event; returns the cycle count right after the accepting edge.
  task automatic send(input bit on, input int pitch, input int wf, input bit keep_valid,
                      input bit push, input exp_t e, output int acc);
    int n = 0;
    acc = -1;
    ev_on = on; ev_pitch = 15'(pitch); ev_waveform = 2'(wf); ev_valid = 1'b1;
    while (!ev_ready && n < 50) begin @(negedge clk); n++; end
    if (!ev_ready) begin
      checks++; fails++;
      $display("FAIL accept_timeout_%s: ev_ready never rose within 50 cycles", e.name);
    end else begin
      acc   = cyc + 1;
      e.acc = acc;
      if (push) sbq.push_back(e);
      @(posedge clk); #1;
      chk({"ready_low_", e.name}, 64'(ev_ready), 64'd0);
    end
    if (!keep_valid) ev_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((sbq.size() != 0 || busy) && n < 100) begin @(negedge clk); n++; end
    if (sbq.size() != 0 || busy) begin
      checks++; fails++;
      $display("FAIL completion_timeout: %0d events outstanding, busy=%0d", sbq.size(), busy);
      sbq.delete();
    end
  endtask

  // Monitor: an event completes on the busy high->low transition.
  bit   prev_busy = 1'b0;
  bit   chk_gap   = 1'b0;
  exp_t me;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_busy = 1'b0;
      chk_gap   = 1'b0;
    end else begin
      if (chk_gap) chk("drop_pulse_width", 64'(ev_dropped), 64'd0);
      chk_gap = 1'b0;
      if (prev_busy && !busy) begin
        if (sbq.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_completion: got completion at cycle %0d expected none", cyc);
        end else begin
          me = sbq.pop_front();
          chk({me.name, "_ena"},     64'(ch_ena),      64'(me.ena));
          chk({me.name, "_pitch"},   64'(ch_pitch),    64'(me.p));
          chk({me.name, "_wf"},      64'(ch_waveform), 64'(me.w));
          chk({me.name, "_dropped"}, 64'(ev_dropped),  64'(me.drop));
          chk({me.name, "_latency"}, 64'(cyc - me.acc), 64'd5);
          chk_gap = me.drop;
        end
      end
      prev_busy = busy;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int a1, a2, a3, ax;
    exp_t none;
    none = mk("none", 4'b0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0);

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ena",     64'(ch_ena),      64'd0);
    chk("rst_ready",   64'(ev_ready),    64'd1);
    chk("rst_busy",    64'(busy),        64'd0);
    chk("rst_dropped", 64'(ev_dropped),  64'd0);
    chk("rst_pitch",   64'(ch_pitch),    64'd0);
    chk("rst_wf",      64'(ch_waveform), 64'd0);

    send(1, 440, 1, 0, 1, mk("on440", 4'b0001, 440, 0, 0, 0, 1, 0, 0, 0, 0), ax);  wait_done();
    send(1, 100, 0, 0, 1, mk("on100", 4'b0011, 440, 100, 0, 0, 1, 0, 0, 0, 0), ax); wait_done();
    send(1, 200, 2, 0, 1, mk("on200", 4'b0111, 440, 100, 200, 0, 1, 0, 2, 0, 0), ax); wait_done();
    send(1, 300, 3, 0, 1, mk("on300", 4'b1111, 440, 100, 200, 300, 1, 0, 2, 3, 0), ax); wait_done();
    send(0, 200, 0, 0, 1, mk("off200", 4'b1011, 440, 100, 200, 300, 1, 0, 2, 3, 0), ax); wait_done();
    send(1, 500, 1, 0, 1, mk("on500", 4'b1111, 440, 100, 500, 300, 1, 0, 1, 3, 0), ax); wait_done();
    send(1, 600, 2, 0, 1, mk("full600", 4'b1111, P0, 100, 500, 300, W0, 0, 1, 3, !STEAL), ax); wait_done();
    send(1, 100, 3, 0, 1, mk("retrig100", 4'b1111, P0, 100, 500, 300, W0, 3, 1, 3, 0), ax); wait_done();
    send(0, 999, 0, 0, 1, mk("off999", 4'b1111, P0, 100, 500, 300, W0, 3, 1, 3, 1), ax); wait_done();
    send(1, 0,   1, 0, 1, mk("on0", 4'b1111, P0, 100, 500, 300, W0, 3, 1, 3, 1), ax);    wait_done();

    send(0, 500, 0, 1, 1, mk("b2b_off500", 4'b1011, P0, 100, 500, 300, W0, 3, 1, 3, 0), a1);
    send(1, 700, 0, 1, 1, mk("b2b_on700", 4'b1111, P0, 100, 700, 300, W0, 3, 0, 3, 0), a2);
    send(0, 100, 0, 0, 1, mk("b2b_off100", 4'b1101, P0, 100, 700, 300, W0, 3, 0, 3, 0), a3);
    wait_done();
    chk("b2b_spacing_1", 64'(a2 - a1), 64'd6);
    chk("b2b_spacing_2", 64'(a3 - a2), 64'd6);

    send(1, 800, 1, 0, 1, mk("on800", 4'b1111, P0, 800, 700, 300, W0, 1, 0, 3, 0), ax); wait_done();
    if (STEAL)
      send(1, 900, 2, 0, 1, mk("steal900", 4'b1111, P0, 800, 700, 900, W0, 1, 0, 2, 0), ax);
    else
      send(1, 900, 2, 0, 1, mk("drop900", 4'b1111, P0, 800, 700, 300, W0, 1, 0, 3, 1), ax);
    wait_done();

    send(1, 1000, 2, 0, 0, none, ax);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midscan_rst_ena",     64'(ch_ena),      64'd0);
    chk("midscan_rst_pitch",   64'(ch_pitch),    64'd0);
    chk("midscan_rst_wf",      64'(ch_waveform), 64'd0);
    chk("midscan_rst_busy",    64'(busy),        64'd0);
    chk("midscan_rst_ready",   64'(ev_ready),    64'd1);
    chk("midscan_rst_dropped", 64'(ev_dropped),  64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    send(1, 440, 1, 0, 1, mk("post_rst440", 4'b0001, 440, 0, 0, 0, 1, 0, 0, 0, 0), ax);
    wait_done();
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Polyphony controller that sequences a bank of NUM_CH tone channels (square/triangle/sine/sawtooth generators).
- Accepts note-on/note-off events over a valid/ready handshake and assigns each note to a channel: retrigger, free slot, or steal the oldest.
- Drives per-channel pitch, waveform and enable. Sits between the note-event source (MIDI/keyboard decoder) and the channel bank/mixer.

Parameters:
- NUM_CH, 4, number of channels managed (2..16).
- MAX_FREQ, 20000, pitch range constant; PITCH_W = $clog2(MAX_FREQ) = 15.
- AGE_W, 4, width of per-channel saturating age counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock; asynchronous, active-low.
- ev_valid  in  1  event present.
- ev_ready  out  1  allocator can accept an event.
- ev_on  in  1  1 = note-on, 0 = note-off.
- ev_pitch  in  PITCH_W  note pitch in ticks.
- ev_waveform  in  2  00 square, 01 triangle, 10 sine, 11 sawtooth (note-on only).
- ch_pitch  out  NUM_CH*PITCH_W  packed per-channel pitch; channel i at [i*PITCH_W +: PITCH_W].
- ch_waveform  out  NUM_CH*2  packed per-channel waveform select.
- ch_ena  out  NUM_CH  1 = channel i sounding.
- busy  out  1  event in progress.
- ev_dropped  out  1  one-cycle pulse when an event is discarded.

Behaviour:
- Reset (async assert, sync-released state):
  - ch_pitch = 0, ch_waveform = 0, ch_ena = 0, all ages = 0.
  - State IDLE: ev_ready = 1, busy = 0, ev_dropped = 0.
- FSM states: IDLE, SCAN, APPLY.
- IDLE: ev_ready = 1. On ev_valid & ev_ready, latch ev_on/ev_pitch/ev_waveform, clear scan index, go to SCAN.
  - ev_valid while not IDLE is held off (ev_ready = 0). The source must hold the event stable until accepted.
- SCAN examines one channel per cycle, index 0..NUM_CH-1, then goes to APPLY. It records:
  - match = lowest i with ch_ena[i] and ch_pitch[i] == latched pitch;
  - free = lowest i with !ch_ena[i];
  - oldest = i with maximum age among enabled channels, lowest index on tie.
- APPLY (one cycle), then return to IDLE.
  - Note-on target priority: match (retrigger, waveform updated), else free, else oldest (steal).
    - Target: ch_pitch/ch_waveform loaded, ch_ena = 1, age = 0.
    - Every other enabled channel: age increments, saturating at 2^AGE_W-1.
  - Note-off: if match, ch_ena[match] = 0 and its pitch/waveform are retained. Otherwise ev_dropped pulses.
  - Note-on with latched pitch == 0 is invalid: no state change, ev_dropped pulses.
- Latency: accept at cycle 0; outputs update at the clock edge ending APPLY, i.e. visible at cycle NUM_CH+2. ev_ready returns high in that same cycle.
- Throughput: one event per NUM_CH+2 cycles.
- busy = (state != IDLE).
- Async reset mid-SCAN/APPLY aborts the event with no partial channel update. After release the latched event is lost.
- Two note-ons with the same pitch retrigger the same channel; no duplicate allocation.

Optional Feature:
- Macro VOICE_STEAL_EN.
- Defined: the steal path is as described above.
- Not defined: oldest-channel tracking and age counters are omitted. A note-on with no match and no free channel is discarded: ev_dropped pulses and channel outputs are unchanged.

Decomposition:
- Package synth_pkg holds:
  - localparam MAX_FREQ = 20000 and PITCH_W;
  - typedef enum logic [1:0] waveform_t {WF_SQUARE, WF_TRIANGLE, WF_SINE, WF_SAWTOOTH};
  - typedef enum logic [1:0] alloc_state_t {IDLE, SCAN, APPLY}.
- One sub-module, voice_slot, instantiated NUM_CH times. It holds pitch, waveform, ena and age for one channel, with load/release/age-increment controls driven from APPLY.

Test Plan (NUM_CH = 4):
- Reset → ch_ena = 0000, ev_ready = 1, busy = 0. Note-on pitch 440, wf 01 → after 6 cycles ch_ena = 0001, ch0 pitch 440, wf 01.
- Note-ons 100/200/300 → channels 1/2/3. Then note-off 200 → ch_ena = 1011 and ch2 pitch stays 200. Then note-on 500 → ch2 gets 500.
- Channels full (0:440, 1:100, 2:500, 3:300), note-on 600:
  - with VOICE_STEAL_EN → ch0 (oldest) gets 600;
  - without → ev_dropped pulse, no change.
- Note-on 100 while 100 is active on ch1 → ch1 retriggered (age 0, new waveform); ch_ena unchanged.
- Note-off 999 (not playing) → ev_dropped pulse. Note-on pitch 0 → ev_dropped pulse, no change.
- ev_valid held high for 3 back-to-back events → ev_ready low during SCAN/APPLY, each event accepted exactly once 6 cycles apart. rst_n asserted in SCAN → all outputs 0 immediately.
